// File: rtl/gpr_scoreboard_arb.sv
// GPR write-port scheduler: a busy-bit scoreboard that stalls issue on RAW/WAW hazards,
// and ALU/LSU writeback arbitration in which a starvation counter hands the LSU priority.
module gpr_scoreboard_arb #(
  parameter int DATA_WIDTH   = 64,
  parameter int RF_SIZE      = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid_i,
  input  logic [RF_SIZE-1:0]      issue_rs1_i,
  input  logic [RF_SIZE-1:0]      issue_rs2_i,
  input  logic [RF_SIZE-1:0]      issue_rd_i,
  input  logic                    issue_rd_we_i,
  output logic                    issue_ready_o,
  input  logic                    alu_wb_valid_i,
  output logic                    alu_wb_ready_o,
  input  logic [RF_SIZE-1:0]      alu_wb_rd_i,
  input  logic [DATA_WIDTH-1:0]   alu_wb_data_i,
  input  logic                    lsu_wb_valid_i,
  output logic                    lsu_wb_ready_o,
  input  logic [RF_SIZE-1:0]      lsu_wb_rd_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wb_data_i,
  output logic                    gpr_we_o,
  output logic [RF_SIZE-1:0]      gpr_rd_o,
  output logic [DATA_WIDTH-1:0]   gpr_data_o,
  output logic [(2**RF_SIZE)-1:0] busy_o,
  output logic                    err_o
);

  localparam int NREG = 2 ** RF_SIZE;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] eff_busy;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] set_mask;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   wait_cnt_d;
  logic            err_q;
  logic            starve;
  logic            alu_ready;
  logic            lsu_ready;
  logic            alu_grant;
  logic            lsu_grant;
  logic            any_grant;
  logic [RF_SIZE-1:0] wb_rd;
  logic            wb_we;
  logic            issue_fire;
  logic            err_set;

  assign starve = (wait_cnt >= CW'(STARVE_LIMIT));

  always_comb begin
    alu_ready = 1'b1;
    lsu_ready = ~alu_wb_valid_i;
    if (starve) begin
      lsu_ready = 1'b1;
      alu_ready = ~lsu_wb_valid_i;
    end
  end

  assign alu_grant = alu_wb_valid_i & alu_ready;
  assign lsu_grant = lsu_wb_valid_i & lsu_ready;
  assign any_grant = alu_grant | lsu_grant;
  assign wb_rd     = lsu_grant ? lsu_wb_rd_i : alu_wb_rd_i;
  assign wb_we     = any_grant & (wb_rd != '0);

  // The write being committed this cycle releases its busy bit for the hazard check,
  // relying on the GPR's write-first bypass to forward the data.
  always_comb begin
    clr_mask = '0;
    if (wb_we) clr_mask[wb_rd] = 1'b1;
  end

  assign eff_busy = busy_q & ~clr_mask;

  assign issue_ready_o = ~(eff_busy[issue_rs1_i] | eff_busy[issue_rs2_i] |
                           (issue_rd_we_i & eff_busy[issue_rd_i]));
  assign issue_fire    = issue_valid_i & issue_ready_o;

  always_comb begin
    set_mask = '0;
    if (issue_fire && issue_rd_we_i && (issue_rd_i != '0)) set_mask[issue_rd_i] = 1'b1;
  end

  // Set is applied after clear so a same-cycle reissue to the released rd stays busy.
  always_comb begin
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    wait_cnt_d = wait_cnt;
    if (!lsu_wb_valid_i || lsu_grant) wait_cnt_d = '0;
    else if (wait_cnt < CW'(STARVE_LIMIT)) wait_cnt_d = wait_cnt + CW'(1);
  end

  assign err_set = wb_we & ~busy_q[wb_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wait_cnt <= wait_cnt_d;
      err_q    <= err_q | err_set;
    end
  end

  assign alu_wb_ready_o = alu_ready;
  assign lsu_wb_ready_o = lsu_ready;
  assign gpr_we_o       = wb_we;
  assign gpr_rd_o       = wb_rd;
  assign gpr_data_o     = lsu_grant ? lsu_wb_data_i : alu_wb_data_i;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule

// File: doc/gpr_scoreboard_arb.md
# gpr_scoreboard_arb

Register-file scheduler that sits in front of the GPR write port and beside the issue stage. It tracks pending destination registers with a busy-bit scoreboard and stalls issue on RAW/WAW hazards. It arbitrates the single GPR write port between the ALU and LSU writeback sources, with a starvation guard for the LSU. It drives the GPR write-port signals directly; the GPR's write-first read bypass is relied on for same-cycle release.

## Interface

- DATA_WIDTH, 64, writeback data width
- RF_SIZE, 5, register index width; 2**RF_SIZE registers; x0 hardwired zero
- STARVE_LIMIT, 4, consecutive LSU-blocked cycles before the LSU is granted priority (≥1)

Ports:

- clk  in  1  rising-edge clock; one clock domain; synchronous, active-high reset
- rst  in  1  synchronous, active-high reset
- issue_valid_i  in  1  instruction presented for issue
- issue_rs1_i, issue_rs2_i  in  RF_SIZE  source indices
- issue_rd_i  in  RF_SIZE  destination index
- issue_rd_we_i  in  1  instruction writes rd
- issue_ready_o  out  1  issue accepted this cycle when valid & ready
- alu_wb_valid_i / alu_wb_ready_o  in/out  1  ALU writeback handshake
- alu_wb_rd_i  in  RF_SIZE; alu_wb_data_i  in  DATA_WIDTH
- lsu_wb_valid_i / lsu_wb_ready_o  in/out  1  LSU writeback handshake
- lsu_wb_rd_i  in  RF_SIZE; lsu_wb_data_i  in  DATA_WIDTH
- gpr_we_o  out  1; gpr_rd_o  out  RF_SIZE; gpr_data_o  out  DATA_WIDTH  GPR write port
- busy_o  out  2**RF_SIZE  scoreboard vector, bit 0 always 0
- err_o  out  1  sticky protocol error

## Operation

- Scoreboard: busy[i] set on an accepted issue with issue_rd_we_i=1 and rd≠0; cleared on a GPR write to i. busy[0] is never set.
- Release wins over hazard in the same cycle:
  - the effective busy for the hazard check is busy[i] & ~(gpr_we_o & gpr_rd_o==i);
  - GPR write-first forwarding supplies the data.
- issue_ready_o = ~(eff_busy[rs1] | eff_busy[rs2] | (issue_rd_we_i & eff_busy[rd])). Combinational from the registered state and the current write grant. Independent of issue_valid_i.
- Same-cycle write clear and issue set on the same rd: the set wins; busy stays 1.
- Arbitration, with starve = (wait_cnt ≥ STARVE_LIMIT):
  - Default: ALU priority. alu_wb_ready_o=1, and lsu_wb_ready_o = ~alu_wb_valid_i.
  - When starve=1: lsu_wb_ready_o=1, and alu_wb_ready_o = ~lsu_wb_valid_i.
  - Exactly one source is granted per cycle. The write-port mux selects the granted source.
  - gpr_we_o = granted valid & rd≠0. A writeback to x0 is consumed with no write.
- wait_cnt behaviour:
  - Increments, saturating at STARVE_LIMIT, each cycle lsu_wb_valid_i=1 and the LSU is not granted.
  - Clears to 0 on an LSU grant or when lsu_wb_valid_i=0.
- err_o is set (sticky until rst) when a granted writeback with rd≠0 targets a register whose busy bit is 0.
- Reset mid-operation: all busy bits clear, wait_cnt=0, and err_o=0. Any writeback in flight at reset is a caller concern; a writeback arriving after reset sets err_o.

## Timing

- State: busy vector, wait_cnt, err_o. All are registered on the rising edge of clk.
- Reset values: busy_o=0, err_o=0, wait_cnt=0.
- After reset, with valids low: issue_ready_o=1, alu_wb_ready_o=1, lsu_wb_ready_o=1, gpr_we_o=0.
- Zero-latency paths: issue_ready_o, both ready outputs, and all gpr_* outputs are combinational in the same cycle.
- Scoreboard update is visible on busy_o one cycle after the accepting edge.
- Issue-to-release:
  - An instruction issued at edge N sets busy at N.
  - The earliest dependent issue is in the cycle whose writeback clears that busy bit.
- Handshakes: a valid source holds rd and data stable until ready. The block never drops a granted transfer.

## Test plan

- Reset then idle:
  - Hold rst=1 two cycles, then release.
  - Required: busy_o=0, issue_ready_o=1, err_o=0, gpr_we_o=0.
- RAW stall and same-cycle release:
  - Issue rd=5 (we=1), then issue rs1=5.
  - Required: issue_ready_o=0 until the cycle ALU writes rd=5 with data 0xDEAD. In that cycle issue_ready_o=1, gpr_we_o=1, gpr_rd_o=5; busy[5] ends 0.
- WAW plus set-wins:
  - Issue rd=7 twice.
  - Required: the second issue stalls, then is accepted in the cycle the first writeback to x7 occurs; busy[7] stays 1.
- Arbitration and starvation (STARVE_LIMIT=4):
  - Hold ALU and LSU valid continuously with distinct busy rds.
  - Required: ALU is granted for 4 cycles, the LSU is granted on the 5th, and wait_cnt then returns to 0.
- x0 handling:
  - Issue rd=0 with we=1, then ALU writeback rd=0.
  - Required: busy_o unchanged, gpr_we_o=0, alu_wb_ready_o=1, err_o=0.
- Protocol error:
  - LSU writeback to rd=3 with busy[3]=0.
  - Required: err_o=1 from the next cycle and held until rst.
